// File: rtl/shake256_padder.sv
// SHAKE256 message padder: packs 64-bit message words into 1088-bit rate blocks
// and applies the 0x1F ... 0x80 domain/pad10*1 padding on the final block.
module shake256_padder (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic          in_last,
  input  logic [3:0]    in_bytes,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1087:0] out_block,
  output logic [10:0]   out_length,
  output logic          out_final
);

  typedef enum logic [1:0] {FILL, EMIT, PADONLY} state_t;

  localparam logic [1087:0] PAD_ONLY_BLOCK = {8'h80, 1072'b0, 8'h1F};

  state_t          r_state;
  state_t          w_state_next;
  logic [1087:0]   r_buf;
  logic [4:0]      r_word_cnt;
  logic            r_pend;
  logic [10:0]     r_len;
  logic            r_final;

  logic            w_accept;
  logic            w_full;
  logic [3:0]      w_cnt_bytes;
  logic [63:0]     w_word;
  logic [7:0]      w_n;
  logic            w_pad_now;
  logic            w_close;
  logic [1087:0]   w_buf_wr;

  function automatic logic [63:0] mask_word(input logic [63:0] d, input logic [3:0] nb);
    mask_word = '0;
    for (int j = 0; j < 8; j++)
      if (4'(j) < nb) mask_word[8*j +: 8] = d[8*j +: 8];
  endfunction

  // Byte n is always zero here because unused bytes are written as zero.
  function automatic logic [1087:0] pad_block(input logic [1087:0] b, input logic [7:0] n);
    pad_block = b;
    for (int k = 0; k < 136; k++)
      if (8'(k) == n) pad_block[8*k +: 8] = 8'h1F;
    pad_block[1087:1080] = pad_block[1087:1080] | 8'h80;
  endfunction

  assign w_accept    = in_valid && in_ready;
  assign w_full      = (r_word_cnt == 5'd16);
  assign w_cnt_bytes = !in_last ? 4'd8 : ((in_bytes > 4'd8) ? 4'd8 : in_bytes);
  assign w_word      = mask_word(in_data, w_cnt_bytes);
  assign w_n         = {r_word_cnt, 3'b000} + {4'b0000, w_cnt_bytes};
  assign w_pad_now   = in_last && (w_n < 8'd136);
  assign w_close     = w_accept && (in_last || w_full);

  always_comb begin
    w_buf_wr = r_buf;
    w_buf_wr[{r_word_cnt, 6'b000000} +: 64] = w_word;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= FILL;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL:    if (w_close)   w_state_next = EMIT;
      EMIT:    if (out_ready) w_state_next = r_pend ? PADONLY : FILL;
      PADONLY: if (out_ready) w_state_next = FILL;
      default:                w_state_next = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == FILL);
    out_valid = (r_state == EMIT) || (r_state == PADONLY);
  end

  // Word counter restarts on the closing word so FILL re-entry needs no extra clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_buf      <= '0;
      r_word_cnt <= '0;
      r_pend     <= 1'b0;
      r_len      <= '0;
      r_final    <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_buf <= w_pad_now ? pad_block(w_buf_wr, w_n) : w_buf_wr;
            if (w_close) begin
              r_word_cnt <= '0;
              r_len      <= w_pad_now ? {w_n, 3'b000} : 11'd1088;
              r_final    <= w_pad_now;
              r_pend     <= in_last && !w_pad_now;
            end else begin
              r_word_cnt <= r_word_cnt + 5'd1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            r_buf   <= r_pend ? PAD_ONLY_BLOCK : '0;
            r_len   <= '0;
            r_final <= r_pend;
          end
        end
        PADONLY: begin
          if (out_ready) begin
            r_buf   <= '0;
            r_pend  <= 1'b0;
            r_final <= 1'b0;
          end
        end
        default: begin
          r_buf <= '0;
        end
      endcase
    end
  end

  assign out_block  = r_buf;
  assign out_length = r_len;
  assign out_final  = r_final;

endmodule

// File: tb/tb_shake256_padder.sv
// Scoreboard bench for shake256_padder: directed messages push expected blocks,
// a negedge monitor pops and compares each block as it is consumed.
module tb_shake256_padder;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic [3:0]    in_bytes = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [1087:0] out_block;
  logic [10:0]   out_length;
  logic          out_final;

  shake256_padder dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_length(out_length), .out_final(out_final)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1087:0] blk;
    logic [10:0]   len;
    logic          fin;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic check_blk(input string name, input logic [1087:0] act, input logic [1087:0] req);
    int first;
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      first = -1;
      for (int k = 135; k >= 0; k--)
        if (act[8*k +: 8] !== req[8*k +: 8]) first = k;
      $display("FAIL %s: byte %0d got %h want %h", name, first,
               act[8*first +: 8], req[8*first +: 8]);
    end
  endtask

  function automatic logic [7:0] mb(input int i);
    return 8'(8'h61 + i);
  endfunction

  function automatic logic [1087:0] exp_block(input int start, input int cnt, input bit pad);
    logic [1087:0] b;
    b = '0;
    for (int i = 0; i < cnt; i++) b[8*i +: 8] = mb(start + i);
    if (pad) begin
      b[8*cnt +: 8] = b[8*cnt +: 8] | 8'h1F;
      b[1087:1080]  = b[1087:1080] | 8'h80;
    end
    return b;
  endfunction

  task automatic push_expected(input int n);
    int off;
    int rem;
    exp_t e;
    off = 0;
    rem = n;
    while (rem >= 136) begin
      e.blk = exp_block(off, 136, 1'b0); e.len = 11'd1088; e.fin = 1'b0;
      q.push_back(e);
      off += 136;
      rem -= 136;
    end
    e.blk = exp_block(off, rem, 1'b1); e.len = 11'(8 * rem); e.fin = 1'b1;
    q.push_back(e);
  endtask

  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int t;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    in_valid = 1'b1;
    t = 0;
    while (1) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        break;
      end
      t++;
      if (t > 100) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles want 1", t);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Non-last words carry a bogus in_bytes; unused bytes carry 0xEE filler.
  task automatic send_msg(input int n, input bit big_bytes);
    int nw;
    int rem;
    logic [63:0] d;
    logic [3:0] nb;
    push_expected(n);
    nw = (n == 0) ? 1 : (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      for (int j = 0; j < 8; j++)
        d[8*j +: 8] = (8*w + j < n) ? mb(8*w + j) : 8'hEE;
      rem = n - 8*w;
      nb  = (w == nw - 1) ? 4'(rem > 8 ? 8 : rem) : 4'd3;
      if (big_bytes && w == nw - 1 && nb == 4'd8) nb = 4'd12;
      send_word(d, w == nw - 1, nb);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 400) begin
      @(posedge clock);
      t++;
    end
    check_val("drain_queue_empty", 64'(q.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset && out_valid) begin
      check_val("in_ready_while_busy", {63'b0, in_ready}, 64'd0);
      if (out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_block: got length %0d final %0b want no block", out_length, out_final);
        end else begin
          m_e = q.pop_front();
          check_blk("block", out_block, m_e.blk);
          check_val("length", 64'(out_length), 64'(m_e.len));
          check_val("final", {63'b0, out_final}, {63'b0, m_e.fin});
        end
      end
    end
  end

  logic [1087:0] snap_blk;
  logic [10:0]   snap_len;
  logic          snap_fin;

  initial begin
    #12;
    check_val("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check_val("rst_out_length", 64'(out_length), 64'd0);
    check_val("rst_out_final", {63'b0, out_final}, 64'd0);
    check_blk("rst_out_block", out_block, '0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_val("rst_in_ready", {63'b0, in_ready}, 64'd1);

    send_msg(3, 1'b0);
    check_val("abc_latency_valid", {63'b0, out_valid}, 64'd1);
    check_val("abc_bytes", 64'(out_block[23:0]), 64'h636261);
    check_val("abc_byte3", 64'(out_block[31:24]), 64'h1F);
    check_val("abc_byte135", 64'(out_block[1087:1080]), 64'h80);
    check_val("abc_length", 64'(out_length), 64'd24);
    drain();

    send_msg(0, 1'b0);
    check_val("empty_byte0", 64'(out_block[7:0]), 64'h1F);
    check_val("empty_byte135", 64'(out_block[1087:1080]), 64'h80);
    drain();

    send_msg(135, 1'b0);
    check_val("m135_byte135", 64'(out_block[1087:1080]), 64'h9F);
    check_val("m135_length", 64'(out_length), 64'd1080);
    drain();

    send_msg(136, 1'b0);
    check_val("m136_length", 64'(out_length), 64'd1088);
    check_val("m136_final", {63'b0, out_final}, 64'd0);
    drain();

    send_msg(8, 1'b1);
    drain();
    send_msg(16, 1'b0);
    drain();
    send_msg(300, 1'b0);
    drain();

    // Backpressure on a held block
    out_ready = 1'b0;
    send_msg(3, 1'b0);
    snap_blk = out_block;
    snap_len = out_length;
    snap_fin = out_final;
    check_val("bp_valid_rise", {63'b0, out_valid}, 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check_blk("bp_block_stable", out_block, snap_blk);
      check_val("bp_length_stable", 64'(out_length), 64'(snap_len));
      check_val("bp_final_stable", {63'b0, out_final}, {63'b0, snap_fin});
      check_val("bp_valid_held", {63'b0, out_valid}, 64'd1);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check_val("bp_back_to_fill", {63'b0, in_ready}, 64'd1);
    check_val("bp_valid_drop", {63'b0, out_valid}, 64'd0);
    drain();

    // Reset in the middle of a 20-word message
    for (int w = 0; w < 9; w++) send_word({8{mb(w)}}, 1'b0, 4'd8);
    reset = 1'b0;
    #1;
    check_val("midrst_valid", {63'b0, out_valid}, 64'd0);
    check_val("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    check_blk("midrst_block", out_block, '0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    send_msg(3, 1'b0);
    check_val("midrst_abc_length", 64'(out_length), 64'd24);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shake256_padder.md
SHAKE256_PADDER -- requirements
Module: shake256_padder

Interface
REQ-001 Parameters: none; the rate is fixed at 1088 bits, i.e. 17 words of 64 bits or 136 bytes.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  a message word is offered.
REQ-005 in_ready  output  1  the padder accepts a word this cycle.
REQ-006 in_data  input  64  message word; byte j is carried on bits [8j+7:8j].
REQ-007 in_last  input  1  the offered word is the final word of the message.
REQ-008 in_bytes  input  4  number of valid low-order bytes in the word; used only when in_last=1.
REQ-009 out_valid  output  1  a padded block is presented.
REQ-010 out_ready  input  1  downstream accepts the block.
REQ-011 out_block  output  1088  block; block byte b is carried on bits [8b+7:8b], and word k fills bits [64k+63:64k].
REQ-012 out_length  output  11  message bits in the block (8 x message bytes), range 0..1088.
REQ-013 out_final  output  1  the block is the last block of the message.

Function
REQ-014 The FSM SHALL have three states: FILL, EMIT and PADONLY.
REQ-015 in_ready SHALL be 1 exactly when the state is FILL; out_valid SHALL be 1 exactly when the state is EMIT or PADONLY.
REQ-016 A word SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; it SHALL be written to word slot word_cnt (0..16), and word_cnt SHALL then increment.
REQ-017 For a word with in_last=0, all 8 bytes SHALL count; in_bytes is ignored.
REQ-018 For a word with in_last=1, in_bytes values 0..8 SHALL count literally; values 9..15 SHALL be treated as 8.
REQ-019 Bytes of a word beyond its counted bytes SHALL be written as zero.
REQ-020 Message byte count n SHALL equal 8*word_cnt plus the counted bytes of the last word.
REQ-021 Padding for n<136: byte n = 0x1F, byte 135 |= 0x80, all bytes strictly between n and 135 = 0x00; for n=135, byte 135 = 0x9F.
REQ-022 FILL->EMIT, case A: the 17th word is accepted with in_last=0. The block is emitted unpadded with out_length=1088 and out_final=0.
REQ-023 FILL->EMIT, case B: a last word is accepted with n<136. The block is emitted padded with out_length=8n and out_final=1.
REQ-024 FILL->EMIT, case C: the 17th word is accepted as last with n=136. The block is emitted unpadded with out_length=1088 and out_final=0, and a pending-pad flag SHALL be set.
REQ-025 out_valid SHALL rise on the cycle after the accepting edge, i.e. a latency of 1 cycle.
REQ-026 While out_valid=1 and out_ready=0, out_block, out_length and out_final SHALL hold stable.
REQ-027 EMIT with out_ready=1, no pending pad: the FSM SHALL go to FILL with word_cnt=0 and the buffer cleared to zero.
REQ-028 EMIT with out_ready=1 and pending pad: the FSM SHALL go to PADONLY and present a block with byte0=0x1F, byte135=0x80, all other bytes zero, out_length=0 and out_final=1.
REQ-029 PADONLY with out_ready=1: the FSM SHALL go to FILL, clear the pending-pad flag and clear the buffer.
REQ-030 If out_ready=1 is sampled in the first EMIT cycle, the block SHALL be consumed with no extra wait cycle.
REQ-031 in_valid in EMIT or PADONLY SHALL be ignored; no word is accepted.
REQ-032 The block count per message is unlimited; full blocks (case A) repeat until a last word arrives.

Reset
REQ-033 reset=0 SHALL immediately force state FILL, word_cnt=0, pending pad=0, buffer=0, out_block=0, out_length=0, out_final=0 and out_valid=0; in_ready SHALL be 1 once reset=1.
REQ-034 Reset asserted mid-message or mid-emit SHALL discard all partial data; the next accepted word is word 0 of a new message.

Verification
REQ-035 Empty message: one word with in_last=1 and in_bytes=0 -> one block, byte0=0x1F, byte135=0x80, out_length=0, out_final=1.
REQ-036 3-byte message "abc": word 0x636261 with in_last=1 and in_bytes=3 -> bytes 0..2 = 61,62,63; byte3=0x1F; byte135=0x80; out_length=24; out_final=1.
REQ-037 135-byte message: 16 full words, then a last word with in_bytes=7 -> byte135=0x9F, out_length=1080, out_final=1.
REQ-038 136-byte message: 17 full words with the last flagged and in_bytes=8 -> block 1 with out_length=1088 and out_final=0, then a pad-only block with out_length=0 and out_final=1; in_ready=0 across both.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles in EMIT -> outputs stable and in_ready=0 throughout; then out_ready=1 -> FILL next cycle.
REQ-040 Reset at word 9 of a 20-word message, then a new 3-byte message -> the only block seen is the new 3-byte block, per REQ-036.
